// File: rtl/tdm_word_packer_pkg.sv
// Shared types and sizing for the TDM word packer.
// FIFO entries are sized for the widest supported configuration.
package tdm_word_packer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_CH_DEF     = 16;
  localparam int WORD_W_DEF     = 512;

  localparam int LANES   = WORD_W_DEF / DATA_WIDTH_DEF;
  localparam int CH_W    = $clog2(NUM_CH_DEF);
  localparam int BYTES_W = $clog2(LANES) + 1;

  // Ceilings for the storage fields: up to 64 channels,
  // up to 512-bit words of 1-bit lanes.
  localparam int MAX_CH_W    = 6;
  localparam int MAX_WORD_W  = 512;
  localparam int MAX_BYTES_W = 10;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ACTIVE,
    CH_DISCARD
  } ch_state_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0]    ch;
    logic                   sop;
    logic                   eop;
    logic [MAX_BYTES_W-1:0] bytes;
    logic [MAX_WORD_W-1:0]  data;
  } fifo_entry_t;

  function automatic int lanes_of(input int word_w,
                                  input int data_w);
    return word_w / data_w;
  endfunction

endpackage

// File: rtl/tdm_word_fifo.sv
// Synchronous FIFO of packed words; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
// Ports: clk, rst, i_push/i_entry, i_pop, o_entry, o_full, o_empty.
module tdm_word_fifo
  import tdm_word_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_entry,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Head is forced to zero when empty so idle outputs read as 0.
  assign o_entry = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/tdm_word_packer.sv
// Packs per-slot TDM bytes into per-channel words (lane 0 at MSBs)
// and queues completed words into one shared output FIFO.
// Ports: clk, rst, slot_en, in_valid/in_sop/in_eop/in_data,
//   cur_slot, out_valid/out_ready, out_ch/out_data/out_sop/
//   out_eop/out_bytes, ovf_flag.
module tdm_word_packer
  import tdm_word_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 16,
  parameter int WORD_W     = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH-1:0]                      slot_en,
  input  logic                                   in_valid,
  input  logic                                   in_sop,
  input  logic                                   in_eop,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  output logic [$clog2(NUM_CH)-1:0]              cur_slot,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(NUM_CH)-1:0]              out_ch,
  output logic [WORD_W-1:0]                      out_data,
  output logic                                   out_sop,
  output logic                                   out_eop,
  output logic [$clog2(WORD_W/DATA_WIDTH):0]     out_bytes,
  output logic [NUM_CH-1:0]                      ovf_flag
);

  localparam int NL  = lanes_of(WORD_W, DATA_WIDTH);
  localparam int NCW = $clog2(NUM_CH);
  localparam int NBW = $clog2(NL) + 1;
  localparam int LW  = (NL > 1) ? $clog2(NL) : 1;

  typedef logic [WORD_W-1:0] word_t;

  logic [NCW-1:0] r_slot;
  ch_state_e      r_st   [NUM_CH];
  logic [LW-1:0]  r_lane [NUM_CH];
  word_t          r_acc  [NUM_CH];
  logic [NUM_CH-1:0] r_sopp;
  logic [NUM_CH-1:0] r_ovf;

  ch_state_e     w_st;
  ch_state_e     w_nxt_st;
  logic [LW-1:0] w_lane;
  logic [LW-1:0] w_pos;
  word_t         w_acc;
  word_t         w_word;
  logic          w_sopp;
  logic          w_act;
  logic          w_start;
  logic          w_cont;
  logic          w_restart;
  logic          w_wr;
  logic          w_last;
  logic          w_done;
  logic          w_drop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  int            w_sh;
  fifo_entry_t   w_entry;
  fifo_entry_t   w_head;
  logic          w_unused;

  // Only the channel owning this cycle is read or updated.
  assign w_st   = r_st[r_slot];
  assign w_lane = r_lane[r_slot];
  assign w_acc  = r_acc[r_slot];
  assign w_sopp = r_sopp[r_slot];

  // Next-state logic for the current slot's channel.
  always_comb begin
    w_act     = slot_en[r_slot] && in_valid;
    w_start   = w_act && in_sop;
    w_cont    = w_act && !in_sop && (w_st == CH_ACTIVE);
    w_restart = w_start && (w_st == CH_ACTIVE);
    w_wr      = w_start || w_cont;
    w_pos     = w_start ? '0 : w_lane;
    w_last    = (w_pos == LW'(NL - 1));
    w_done    = w_wr && (w_last || in_eop);
    // Full never coexists with empty, so a ready sink always pops.
    w_drop    = w_done && w_full && !out_ready;
    w_nxt_st  = w_st;
    if (w_wr) begin
      if (w_done && in_eop) w_nxt_st = CH_IDLE;
      else if (w_drop)      w_nxt_st = CH_DISCARD;
      else                  w_nxt_st = CH_ACTIVE;
    end
  end

  // Datapath: merge the byte and build the FIFO entry.
  always_comb begin
    w_sh   = (NL - 1 - int'(w_pos)) * DATA_WIDTH;
    w_word = (w_start ? '0 : w_acc)
           | (word_t'(in_data) << w_sh);
    w_entry       = '0;
    w_entry.ch    = MAX_CH_W'(r_slot);
    w_entry.sop   = w_start || w_sopp;
    w_entry.eop   = in_eop;
    w_entry.bytes = MAX_BYTES_W'(w_pos) + MAX_BYTES_W'(1);
    w_entry.data  = MAX_WORD_W'(w_word);
    w_push        = w_done && !rst;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_sopp <= '0;
      r_ovf  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]   <= CH_IDLE;
        r_lane[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      r_slot <= (r_slot == NCW'(NUM_CH - 1))
              ? '0 : r_slot + 1'b1;
      r_st[r_slot] <= w_nxt_st;
      if (w_wr) begin
        if (w_done) begin
          r_lane[r_slot] <= '0;
          r_acc[r_slot]  <= '0;
          r_sopp[r_slot] <= 1'b0;
        end else begin
          r_lane[r_slot] <= w_pos + 1'b1;
          r_acc[r_slot]  <= w_word;
          r_sopp[r_slot] <= w_start || w_sopp;
        end
      end
      if (w_restart || w_drop) r_ovf[r_slot] <= 1'b1;
    end
  end

  tdm_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (out_ready),
    .o_entry (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cur_slot  = r_slot;
  assign ovf_flag  = r_ovf;
  assign out_valid = !w_empty;
  assign out_ch    = w_head.ch[NCW-1:0];
  assign out_sop   = w_head.sop;
  assign out_eop   = w_head.eop;
  assign out_bytes = w_head.bytes[NBW-1:0];
  assign out_data  = w_head.data[WORD_W-1:0];

  // Upper storage bits beyond this configuration stay zero.
  assign w_unused = ^w_head;

endmodule

// File: tb/tb_tdm_word_packer.sv
// Directed bench for tdm_word_packer with an expected-word queue.
// Config: 8-bit lanes, 32-bit words, 4 channels, 4-entry FIFO.
module tb_tdm_word_packer;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int WW  = 32;
  localparam int FD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  slot_en = 4'hF;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  cur_slot;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_bytes;
  logic [3:0]  ovf_flag;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic        sop;
    logic        eop;
    logic [2:0]  bytes;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e_pop;

  tdm_word_packer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .WORD_W     (WW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .slot_en   (slot_en),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .cur_slot  (cur_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_bytes (out_bytes),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic s,
                              input logic e, input int b,
                              input logic [31:0] d);
    exp_t x;
    x.ch    = 2'(ch);
    x.sop   = s;
    x.eop   = e;
    x.bytes = 3'(b);
    x.data  = d;
    return x;
  endfunction

  function automatic logic [7:0] bv(input int ch, input int r);
    return 8'((ch + 1) * 16 + r);
  endfunction

  // Accepted words are compared at the negedge before the pop edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word observed=%0h expected=none",
               {out_ch, out_sop, out_eop, out_bytes, out_data});
      end else begin
        e_pop = q.pop_front();
        chk("word", {out_ch, out_sop, out_eop, out_bytes, out_data},
            e_pop);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_slot(input int ch);
    int n = 0;
    while (cur_slot != 2'(ch) && n < 2 * NCH) begin
      idle(1);
      n++;
    end
    if (cur_slot != 2'(ch)) begin
      checks++;
      errors++;
      $error("FAIL slot_wait observed=%0d expected=%0d",
             cur_slot, ch);
    end
  endtask

  task automatic send(input int ch, input logic [7:0] d,
                      input logic s, input logic e);
    wait_slot(ch);
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_slot", cur_slot, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_out", {out_ch, out_sop, out_eop, out_bytes, out_data}, 0);
    rst = 1'b0;

    // Single full-word packet, latency one cycle
    q.push_back(mk(1, 1, 1, 4, 32'h11223344));
    send(1, 8'h11, 1, 0);
    send(1, 8'h22, 0, 0);
    send(1, 8'h33, 0, 0);
    send(1, 8'h44, 0, 1);
    chk("latency_valid", out_valid, 1);
    idle(2);

    // Six-byte packet spanning two words
    q.push_back(mk(2, 1, 0, 4, 32'h01020304));
    q.push_back(mk(2, 0, 1, 2, 32'h05060000));
    for (int i = 1; i <= 6; i++)
      send(2, 8'(i), i == 1, i == 6);
    idle(3);
    chk("pkt6_drained", q.size(), 0);

    // Interleaved packets with a stalled sink
    out_ready = 1'b0;
    for (int c = 0; c < NCH; c++)
      q.push_back(mk(c, 1, 1, 4,
                     {bv(c, 0), bv(c, 1), bv(c, 2), bv(c, 3)}));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NCH; c++)
        send(c, bv(c, r), r == 0, r == 3);
    held = out_data;
    idle(3);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, held);
    chk("hold_ch", out_ch, 0);
    // Fifth word overflows and is dropped
    send(0, 8'hA0, 1, 0);
    send(0, 8'hA1, 0, 0);
    send(0, 8'hA2, 0, 0);
    send(0, 8'hA3, 0, 0);
    chk("ovf_drop", ovf_flag, 4'b0001);
    send(0, 8'hA4, 0, 0);
    send(0, 8'hA5, 0, 1);
    // Push into full FIFO together with a pop is accepted
    wait_slot(1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    in_data   = 8'h5A;
    q.push_back(mk(1, 1, 1, 1, 32'h5A000000));
    step();
    idle(1);
    chk("ovf_full_pop", ovf_flag, 4'b0001);
    idle(8);
    chk("stall_drained", q.size(), 0);
    chk("stall_idle", out_valid, 0);
    // Discarding channel recovers on a new sop
    q.push_back(mk(0, 1, 1, 1, 32'h77000000));
    send(0, 8'h77, 1, 1);
    idle(3);
    chk("discard_recover", q.size(), 0);

    // Restart mid-packet on ch3
    q.push_back(mk(3, 1, 1, 4, 32'hB1B2B3B4));
    send(3, 8'hC1, 1, 0);
    send(3, 8'hC2, 0, 0);
    send(3, 8'hB1, 1, 0);
    send(3, 8'hB2, 0, 0);
    send(3, 8'hB3, 0, 0);
    send(3, 8'hB4, 0, 1);
    chk("ovf_restart", ovf_flag, 4'b1001);
    idle(3);
    chk("restart_drained", q.size(), 0);

    // Reset mid-packet
    send(0, 8'hD0, 1, 0);
    send(0, 8'hD1, 0, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_slot", cur_slot, 0);
    chk("mid_rst_ovf", ovf_flag, 0);
    chk("mid_rst_out",
        {out_valid, out_ch, out_sop, out_eop, out_bytes, out_data}, 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_valid", out_valid, 0);
    q.push_back(mk(0, 1, 1, 4, 32'hE1E2E3E4));
    send(0, 8'hE1, 1, 0);
    send(0, 8'hE2, 0, 0);
    send(0, 8'hE3, 0, 0);
    send(0, 8'hE4, 0, 1);
    idle(3);
    chk("post_rst_ovf", ovf_flag, 0);
    chk("post_rst_drained", q.size(), 0);

    // Disabled slot
    slot_en = 4'b1011;
    send(2, 8'hF1, 1, 0);
    send(2, 8'hF2, 0, 0);
    send(2, 8'hF3, 0, 0);
    send(2, 8'hF4, 0, 1);
    wait_slot(0);
    for (int i = 0; i < 5; i++) begin
      chk("slot_seq", cur_slot, i % NCH);
      idle(1);
    end
    idle(3);
    chk("disabled_valid", out_valid, 0);
    chk("disabled_ovf", ovf_flag, 0);
    slot_en = 4'hF;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
